// File: rtl/ula_pkg.sv
// ula_pkg: opcode encoding and flag/condition record shared by the ula datapath and its wrappers
package ula_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_RSV6, OP_RSV7
  } alu_op_t;
  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
    logic hs;
    logic ls;
    logic hi;
    logic lo;
    logic illegal;
  } ula_flags_t;
  localparam ula_flags_t FLAGS_RST = '{z: 1'b1, c: 1'b0, v: 1'b0, n: 1'b0, hs: 1'b0,
                                      ls: 1'b1, hi: 1'b0, lo: 1'b1, illegal: 1'b0};
endpackage

// File: rtl/ula_core.sv
// ula_core: combinational ALU op with NZCV flags and unsigned compare conditions
module ula_core
  import ula_pkg::*;
#(
  parameter int ULA_BITS = 4
) (
  input  logic [ULA_BITS-1:0] a,
  input  logic [ULA_BITS-1:0] b,
  input  alu_op_t             op,
  output logic [ULA_BITS-1:0] result,
  output ula_flags_t          flags
);
  localparam int M = ULA_BITS - 1;
  logic [ULA_BITS:0]   sum;
  logic [ULA_BITS-1:0] bb;
  logic                arith;
  logic                is_sub;
  // SUB shares the adder as a + ~b + 1; carry/overflow only meaningful for ADD/SUB
  always_comb begin
    is_sub = op == OP_SUB;
    arith = op == OP_ADD || is_sub;
    bb = is_sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{ULA_BITS{1'b0}}, is_sub};
    result = arith ? sum[M:0] :
             op == OP_AND ? a & b :
             op == OP_OR  ? a | b :
             op == OP_XOR ? a ^ b :
             op == OP_SLT ? {{M{1'b0}}, $signed(a) < $signed(b)} : '0;
    flags.z = result == '0;
    flags.n = result[M];
    flags.c = arith & sum[ULA_BITS];
    flags.v = arith & (a[M] == bb[M]) & (sum[M] != a[M]);
    flags.hs = flags.c;
    flags.lo = ~flags.c;
    flags.hi = flags.c & ~flags.z;
    flags.ls = ~flags.c | flags.z;
    flags.illegal = op == OP_RSV6 || op == OP_RSV7;
  end
endmodule

// File: rtl/ula_exec_unit.sv
// ula_exec_unit: handshaked, registered ula with a one-entry skid and a saturating handoff counter
module ula_exec_unit
  import ula_pkg::*;
#(
  parameter int ULA_BITS = 4,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ULA_BITS-1:0] a,
  input  logic [ULA_BITS-1:0] b,
  input  logic [2:0]          ALUControl,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ULA_BITS-1:0] result,
  output logic                zero,
  output logic                carry,
  output logic                overflow,
  output logic                negative,
  output logic                hs,
  output logic                ls,
  output logic                hi,
  output logic                lo,
  output logic                illegal,
  output logic [CNT_BITS-1:0] ops_done
);
  typedef struct packed {
    logic [ULA_BITS-1:0] result;
    ula_flags_t          f;
  } rec_t;
  localparam rec_t REC_RST = '{result: '0, f: FLAGS_RST};
  rec_t                new_rec, r_d, r_q, s_d, s_q;
  logic                r_valid_d, r_valid_q, s_valid_d, s_valid_q;
  logic [CNT_BITS-1:0] cnt_d, cnt_q;
  logic                accept, handoff;
  // operands are gated so idle-cycle X on a/b never reaches the datapath
  ula_core #(.ULA_BITS(ULA_BITS)) u_core (
    .a      (req_valid ? a : '0),
    .b      (req_valid ? b : '0),
    .op     (alu_op_t'(ALUControl)),
    .result (new_rec.result),
    .flags  (new_rec.f)
  );
  // R/S occupancy: S only fills when R is held, and drains into R on the next handoff
  always_comb begin
    accept = req_valid & ~s_valid_q;
    handoff = r_valid_q & rsp_ready;
    r_d = s_valid_q ? (handoff ? s_q : r_q) : (accept & (~r_valid_q | handoff)) ? new_rec : r_q;
    r_valid_d = s_valid_q | (r_valid_q & ~handoff) | accept;
    s_valid_d = s_valid_q ? ~handoff : r_valid_q & ~handoff & accept;
    s_d = (~s_valid_q & r_valid_q & ~handoff & accept) ? new_rec : s_q;
    cnt_d = cnt_q + CNT_BITS'(handoff & ~&cnt_q);
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= REC_RST;
      s_q <= REC_RST;
      r_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      r_q <= r_d;
      s_q <= s_d;
      r_valid_q <= r_valid_d;
      s_valid_q <= s_valid_d;
      cnt_q <= cnt_d;
    end
  end
  assign req_ready = ~s_valid_q;
  assign rsp_valid = r_valid_q;
  assign result = r_q.result;
  assign zero = r_q.f.z;
  assign carry = r_q.f.c;
  assign overflow = r_q.f.v;
  assign negative = r_q.f.n;
  assign hs = r_q.f.hs;
  assign ls = r_q.f.ls;
  assign hi = r_q.f.hi;
  assign lo = r_q.f.lo;
  assign illegal = r_q.f.illegal;
  assign ops_done = cnt_q;
endmodule

// File: tb/tb_ula_exec_unit.sv
// tb_ula_exec_unit: directed and randomized checks of the execution unit against a 2-deep FIFO model
module tb_ula_exec_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       rsp_ready = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [2:0] op = '0;
  logic       req_ready, rsp_valid, zero, carry, overflow, negative, hs, ls, hi, lo, illegal;
  logic [3:0] result;
  logic [7:0] ops_done;
  logic       req_ready2, rsp_valid2, zero2, carry2, overflow2, negative2, hs2, ls2, hi2, lo2, illegal2;
  logic [3:0] result2;
  logic [1:0] ops_done2;
  logic [12:0] obs, obs2;
  logic [12:0] q[$];
  int hn = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ula_exec_unit #(.ULA_BITS(4), .CNT_BITS(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .ALUControl(op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow), .negative(negative),
    .hs(hs), .ls(ls), .hi(hi), .lo(lo), .illegal(illegal), .ops_done(ops_done));

  ula_exec_unit #(.ULA_BITS(4), .CNT_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
    .a(a), .b(b), .ALUControl(op), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .result(result2), .zero(zero2), .carry(carry2), .overflow(overflow2), .negative(negative2),
    .hs(hs2), .ls(ls2), .hi(hi2), .lo(lo2), .illegal(illegal2), .ops_done(ops_done2));

  assign obs = {result, zero, carry, overflow, negative, hs, ls, hi, lo, illegal};
  assign obs2 = {result2, zero2, carry2, overflow2, negative2, hs2, ls2, hi2, lo2, illegal2};

  function automatic logic [12:0] ref_rsp(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
    int sx, sy, s;
    logic [3:0] r;
    logic c, v, z, ill;
    sx = $signed(x);
    sy = $signed(y);
    c = 1'b0;
    v = 1'b0;
    ill = 1'b0;
    r = '0;
    case (o)
      3'd0: begin s = x + y; r = 4'(s); c = s > 15; v = (sx + sy > 7) || (sx + sy < -8); end
      3'd1: begin r = 4'(x - y); c = x >= y; v = (sx - sy > 7) || (sx - sy < -8); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = (sx < sy) ? 4'd1 : 4'd0;
      default: ill = 1'b1;
    endcase
    z = r == 0;
    return {r, z, c, v, r[3], c, !c || z, c && !z, !c, ill};
  endfunction

  // scoreboard: a plain 2-entry FIFO, pop on handoff, push on accept
  always @(posedge clk) begin
    bit h, acc;
    if (reset) begin
      q.delete();
      hn = 0;
    end else begin
      h = q.size() > 0 && rsp_ready;
      acc = req_valid && q.size() < 2;
      if (h) begin
        void'(q.pop_front());
        hn++;
      end
      if (acc) q.push_back(ref_rsp(a, b, op));
    end
  end

  task automatic drv(input logic rv, input logic [3:0] x, input logic [3:0] y, input logic [2:0] o, input logic rr);
    req_valid = rv;
    a = x;
    b = y;
    op = o;
    rsp_ready = rr;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drv(1'b0, 4'bx, 4'bx, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (ops_done !== 8'd0) begin bad++; $display("FAIL reset_ops got=%0d exp=0", ops_done); end
    total++; if (obs !== {4'b0000, 9'b100001010}) begin bad++; $display("FAIL reset_record got=%b exp=%b", obs, {4'b0000, 9'b100001010}); end
  endtask

  task automatic test_add;
    @(negedge clk) drv(1'b1, 4'b0111, 4'b0001, 3'd0, 1'b1);
    @(negedge clk) drv(1'b0, 4'bx, 4'bx, 3'd0, 1'b1);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", rsp_valid); end
    total++; if (obs !== {4'b1000, 9'b001101010}) begin bad++; $display("FAIL add_record got=%b exp=%b", obs, {4'b1000, 9'b001101010}); end
    @(negedge clk);
    total++; if (ops_done !== 8'd1) begin bad++; $display("FAIL add_ops got=%0d exp=1", ops_done); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_drained got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_sub;
    @(negedge clk) drv(1'b1, 4'b0011, 4'b0101, 3'd1, 1'b1);
    @(negedge clk) drv(1'b1, 4'b0101, 4'b0101, 3'd1, 1'b1);
    total++; if (obs !== {4'b1110, 9'b000101010}) begin bad++; $display("FAIL sub_neg got=%b exp=%b", obs, {4'b1110, 9'b000101010}); end
    @(negedge clk) drv(1'b0, 4'bx, 4'bx, 3'd0, 1'b1);
    total++; if (obs !== {4'b0000, 9'b110011000}) begin bad++; $display("FAIL sub_eq got=%b exp=%b", obs, {4'b0000, 9'b110011000}); end
    @(negedge clk);
    total++; if (ops_done !== 8'd3) begin bad++; $display("FAIL sub_ops got=%0d exp=3", ops_done); end
  endtask

  task automatic test_illegal;
    @(negedge clk) drv(1'b1, 4'b1111, 4'b1111, 3'd7, 1'b1);
    @(negedge clk) drv(1'b0, 4'bx, 4'bx, 3'd0, 1'b1);
    total++; if (obs !== {4'b0000, 9'b100001011}) begin bad++; $display("FAIL illegal_record got=%b exp=%b", obs, {4'b0000, 9'b100001011}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [12:0] ea, eb, ec;
    ea = ref_rsp(4'd2, 4'd3, 3'd0);
    eb = ref_rsp(4'd1, 4'd4, 3'd1);
    ec = ref_rsp(4'd9, 4'd6, 3'd4);
    @(negedge clk) drv(1'b1, 4'd2, 4'd3, 3'd0, 1'b0);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b exp=1", req_ready); end
    @(negedge clk);
    total++; if (obs !== ea || rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_first got=%b/%b exp=%b/1", obs, rsp_valid, ea); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", req_ready); end
    drv(1'b1, 4'd1, 4'd4, 3'd1, 1'b0);
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", req_ready); end
    drv(1'b1, 4'd9, 4'd6, 3'd4, 1'b0);
    @(negedge clk);
    total++; if (obs !== ea || req_ready !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b/%b exp=%b/0", obs, req_ready, ea); end
    drv(1'b1, 4'd9, 4'd6, 3'd4, 1'b1);
    @(negedge clk);
    total++; if (obs !== eb || req_ready !== 1'b1) begin bad++; $display("FAIL bp_second got=%b/%b exp=%b/1", obs, req_ready, eb); end
    @(negedge clk) drv(1'b0, 4'bx, 4'bx, 3'd0, 1'b1);
    total++; if (obs !== ec || rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_third got=%b/%b exp=%b/1", obs, rsp_valid, ec); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || ops_done !== 8'd7) begin bad++; $display("FAIL bp_done got=%b/%0d exp=0/7", rsp_valid, ops_done); end
  endtask

  task automatic test_reset_midstall;
    @(negedge clk) drv(1'b1, 4'd5, 4'd2, 3'd0, 1'b0);
    @(negedge clk) drv(1'b1, 4'd6, 4'd2, 3'd2, 1'b0);
    @(negedge clk) drv(1'b1, 4'd7, 4'd2, 3'd3, 1'b0);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL midstall_full got=%b exp=0", req_ready); end
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    drv(1'b0, 4'bx, 4'bx, 3'd0, 1'b0);
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL midstall_hs got=%b%b exp=01", rsp_valid, req_ready); end
    total++; if (ops_done !== 8'd0 || ops_done2 !== 2'd0) begin bad++; $display("FAIL midstall_ops got=%0d/%0d exp=0/0", ops_done, ops_done2); end
    total++; if (obs !== {4'b0000, 9'b100001010}) begin bad++; $display("FAIL midstall_record got=%b exp=%b", obs, {4'b0000, 9'b100001010}); end
  endtask

  task automatic test_saturate;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk) drv(1'b1, 4'(i), 4'(i), 3'd0, 1'b1);
      @(negedge clk) drv(1'b0, 4'bx, 4'bx, 3'd0, 1'b1);
      @(negedge clk);
      total++; if (ops_done2 !== 2'(i < 3 ? i : 3)) begin bad++; $display("FAIL sat_ops2 i=%0d got=%0d exp=%0d", i, ops_done2, i < 3 ? i : 3); end
      total++; if (ops_done !== 8'(i)) begin bad++; $display("FAIL sat_ops8 i=%0d got=%0d exp=%0d", i, ops_done, i); end
    end
  endtask

  task automatic test_random;
    logic rv;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!reset) begin
        total++; if (rsp_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, rsp_valid, q.size() > 0); end
        total++; if (req_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, req_ready, q.size() < 2); end
        if (q.size() > 0) begin
          total++; if (obs !== q[0]) begin bad++; $display("FAIL rnd_record i=%0d got=%b exp=%b", i, obs, q[0]); end
        end
        total++; if (ops_done !== 8'(hn < 255 ? hn : 255)) begin bad++; $display("FAIL rnd_ops8 i=%0d got=%0d exp=%0d", i, ops_done, hn < 255 ? hn : 255); end
        total++; if (ops_done2 !== 2'(hn < 3 ? hn : 3) || obs2 !== obs) begin bad++; $display("FAIL rnd_dut2 i=%0d got=%0d/%b exp=%0d/%b", i, ops_done2, obs2, hn < 3 ? hn : 3, obs); end
      end
      reset = (i == 200);
      rv = ($urandom % 3) != 0;
      if (rv) drv(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), ($urandom % 4) != 0);
      else drv(1'b0, 4'bx, 4'bx, 3'($urandom), ($urandom % 4) != 0);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_illegal;
    test_back_to_back;
    test_reset_midstall;
    test_saturate;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
